// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared constants and types for the fetch sequencer: instruction encodings,
// fault codes and the fetch state enum.
package riscv_core_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bundle of ROM, redirect, IF/ID handshake and status signals of the fetch sequencer.
// master = fetch controller, slave = surrounding core (ROM, decode, branch unit).
interface instr_fetch_ctrl_if #(parameter int W = 32);
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_rd;
    logic         redirect_valid;
    logic [W-1:0] redirect_pc;
    logic         if_valid;
    logic         if_ready;
    logic [W-1:0] if_instr;
    logic [W-1:0] if_pc;
    logic         fault;
    logic [1:0]   fault_code;
    logic         halted;
    logic [31:0]  fetch_cnt;

    modport master (
        output imem_addr,
        input  imem_rd,
        input  redirect_valid, redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr, if_pc, fault, fault_code, halted, fetch_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_rd,
        output redirect_valid, redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr, if_pc, fault, fault_code, halted, fetch_cnt
    );
endinterface

// File: rtl/instr_fetch_ctrl_pc_next_gen.sv
// Combinational next-PC select (redirect > advance > hold) and fetch-address checks.
module pc_next_gen #(
    parameter int W     = 32,
    parameter int DEPTH = 256
) (
    input  logic [W-1:0] pc_i,
    input  logic         redirect_valid_i,
    input  logic [W-1:0] redirect_pc_i,
    input  logic         advance_i,
    output logic [W-1:0] pc_d_o,
    output logic         misalign_o,
    output logic         range_err_o
);
    always_comb begin
        pc_d_o = pc_i;
        if (redirect_valid_i)
            pc_d_o = redirect_pc_i;
        else if (advance_i)
            pc_d_o = pc_i + W'(4);
    end

    assign misalign_o  = (pc_i[1:0] != 2'b00);
    assign range_err_o = (pc_i >= W'(DEPTH * 4));
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the instruction ROM and feeds decode through
// a one-entry IF/ID register. Optional feature macro: HALT_ON_EBREAK_EN.
module instr_fetch_ctrl
    import riscv_core_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = '0,
    parameter int           DEPTH    = 256
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_ctrl_if.master  bus
);
    fetch_state_t state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [W-1:0] if_instr_q, if_instr_d;
    logic [W-1:0] if_pc_q, if_pc_d;
    logic         fault_q, fault_d;
    logic [1:0]   fault_code_q, fault_code_d;
    logic [31:0]  fetch_cnt_q;

    logic hs, in_fetch, redir, misalign, range_err, flt_hit, capture, ebreak_hit, advance;

    assign hs       = if_valid_q & bus.if_ready;
    assign in_fetch = (state_q == ST_FETCH);
    assign redir    = bus.redirect_valid;
    assign flt_hit  = in_fetch & ~redir & (misalign | range_err);
    assign capture  = in_fetch & ~redir & ~flt_hit & (~if_valid_q | bus.if_ready);

`ifdef HALT_ON_EBREAK_EN
    assign ebreak_hit = capture & (bus.imem_rd == EBREAK_INSTR);
`else
    assign ebreak_hit = 1'b0;
`endif

    // An ebreak is delivered but the PC parks on it so a resume redirect is explicit.
    assign advance = capture & ~ebreak_hit;

    pc_next_gen #(.W(W), .DEPTH(DEPTH)) u_pc_next (
        .pc_i             (pc_q),
        .redirect_valid_i (redir),
        .redirect_pc_i    (bus.redirect_pc),
        .advance_i        (advance),
        .pc_d_o           (pc_d),
        .misalign_o       (misalign),
        .range_err_o      (range_err)
    );

    always_comb begin
        state_d      = state_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            default: begin
                if (redir) begin
                    state_d      = ST_FETCH;
                    if_valid_d   = 1'b0;
                    fault_d      = 1'b0;
                    fault_code_d = FLT_NONE;
                end else if (flt_hit) begin
                    // The pending word is left to drain; only the fetch stops.
                    state_d      = ST_HALT;
                    fault_d      = 1'b1;
                    fault_code_d = misalign ? FLT_MISALIGN : FLT_RANGE;
                    if (hs) if_valid_d = 1'b0;
                end else if (capture) begin
                    if_valid_d = 1'b1;
                    if_instr_d = bus.imem_rd;
                    if_pc_d    = pc_q;
                    if (ebreak_hit) state_d = ST_HALT;
                end else if (hs) begin
                    if_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_instr_q   <= W'(NOP_INSTR);
            if_pc_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            fetch_cnt_q  <= fetch_cnt_q + 32'(hs);
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.if_instr   = if_instr_q;
    assign bus.if_pc      = if_pc_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.fetch_cnt  = fetch_cnt_q;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed latency/back-pressure/redirect cases
// followed by randomized redirect targets and random decode back-pressure.
module tb_instr_fetch_ctrl;
    import riscv_core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_ctrl_if #(.W(32)) bus();

    instr_fetch_ctrl #(.W(32), .RESET_PC(32'h0), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom [256];
    assign bus.imem_rd = (bus.imem_addr < 32'h400) ? rom[bus.imem_addr[9:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors   = 0;
    int   checks   = 0;
    int   hs_model = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: from a target, the delivered stream is every word up to the end of
    // the ROM (or up to and including an ebreak when that feature is built in).
    function automatic logic [1:0] push_stream(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 2'b01;
        while (a < 32'h400) begin
            q.push_back('{pc: a, instr: rom[a[9:2]]});
`ifdef HALT_ON_EBREAK_EN
            if (rom[a[9:2]] == EBREAK_INSTR) return 2'b00;
`endif
            a += 32'd4;
        end
        return 2'b10;
    endfunction

    // Monitor: fetch_cnt must equal handshakes seen so far; each handshake pops one word.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hs_model = 0;
        end else begin
            chk("fetch_cnt", bus.fetch_cnt, hs_model);
            if (bus.if_valid && bus.if_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got pc %h expected none", bus.if_pc);
                end else begin
                    e = q.pop_front();
                    chk("if_pc", bus.if_pc, e.pc);
                    chk("if_instr", bus.if_instr, e.instr);
                end
                hs_model++;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_if_valid"},  32'(bus.if_valid), 32'd0);
        chk({tag, "_if_instr"},  bus.if_instr, NOP_INSTR);
        chk({tag, "_if_pc"},     bus.if_pc, 32'd0);
        chk({tag, "_fault"},     32'(bus.fault), 32'd0);
        chk({tag, "_code"},      32'(bus.fault_code), 32'd0);
        chk({tag, "_halted"},    32'(bus.halted), 32'd0);
        chk({tag, "_fetch_cnt"}, bus.fetch_cnt, 32'd0);
        chk({tag, "_imem_addr"}, bus.imem_addr, 32'd0);
    endtask

    // Redirect to tgt, run until HALT, drain the IF/ID stage and check the final status.
    task automatic run_from(input logic [31:0] tgt, input bit rnd_ready);
        logic [1:0] ec;
        bit         done;
        ec = push_stream(tgt);
        bus.redirect_pc    = tgt;
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        chk("fault_clr", 32'(bus.fault), 32'd0);
        chk("halt_clr", 32'(bus.halted), 32'd0);
        done = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (bus.halted) begin done = 1'b1; break; end
            bus.if_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL halt_timeout: got running expected halted, target %h", tgt);
        end
        bus.if_ready = 1'b1;
        for (int n = 0; n < 4 && bus.if_valid; n++) tick();
        chk("drained", 32'(bus.if_valid), 32'd0);
        chk("halted", 32'(bus.halted), 32'd1);
        chk("fault", 32'(bus.fault), 32'(ec != 2'b00));
        chk("fault_code", 32'(bus.fault_code), 32'(ec));
        chk("leftover", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] tgt;
        int          r;
        for (int i = 0; i < 256; i++) begin
            rom[i] = $urandom;
            if (rom[i] == EBREAK_INSTR) rom[i] = rom[i] ^ 32'h1;
        end
        rom[8] = EBREAK_INSTR;
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        tick();
        tick();
        check_reset_vals("rst");
        for (int a = 0; a < 16; a += 4) q.push_back('{pc: 32'(a), instr: rom[a / 4]});
        rst = 1'b0;

        // Boot cycle, then one word per cycle.
        tick();
        chk("boot_valid", 32'(bus.if_valid), 32'd0);
        tick();
        chk("lat_pc0", bus.if_pc, 32'h0);
        chk("lat_valid", 32'(bus.if_valid), 32'd1);
        tick();
        chk("seq_pc4", bus.if_pc, 32'h4);
        tick();
        chk("seq_pc8", bus.if_pc, 32'h8);
        bus.if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_pc", bus.if_pc, 32'h8);
            chk("bp_instr", bus.if_instr, rom[2]);
            chk("bp_addr", bus.imem_addr, 32'hC);
            chk("bp_cnt", bus.fetch_cnt, 32'd2);
        end
        bus.if_ready = 1'b1;
        tick();
        chk("rel_pc12", bus.if_pc, 32'hC);

        // Redirect coinciding with a handshake: counted, flushed, then target fetched.
        q.push_back('{pc: 32'h40, instr: rom[16]});
        bus.redirect_pc    = 32'h40;
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        chk("flush_valid", 32'(bus.if_valid), 32'd0);
        chk("flush_cnt", bus.fetch_cnt, 32'd4);
        tick();
        chk("redir_pc", bus.if_pc, 32'h40);

        run_from(32'h42, 1'b0);
        run_from(32'h10, 1'b1);

        for (int it = 0; it < 10; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      tgt = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            else if (r < 3) tgt = 32'h400 + (32'($urandom_range(0, 63)) << 2);
            else            tgt = 32'h400 - (32'($urandom_range(1, 48)) << 2);
            run_from(tgt, 1'b1);
        end

        // Reset in the middle of a run takes effect immediately.
        void'(push_stream(32'h100));
        bus.redirect_pc    = 32'h100;
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        tick();
        void'(push_stream(32'h0));
        rst = 1'b0;
        tick();
        chk("reboot_valid", 32'(bus.if_valid), 32'd0);
        tick();
        chk("reboot_pc", bus.if_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
